// File: rtl/pipe_stage_skid_pkg.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid_pkg
//   Shared constants for the generic pipeline-stage register and its callers.
//   Holds the default payload/counter widths and the per-boundary payload
//   widths. Field packing into these widths stays with each instantiating stage.
//
// Optional feature macro: PIPE_STAGE_PERF_EN (consumed by pipe_stage_skid)
// -----------------------------------------------------------------------------
package pipe_stage_skid_pkg;

    // Default payload width of a stage register
    localparam int PIPE_DEFAULT_WIDTH = 32;

    // Default width of the optional performance counters
    localparam int PIPE_CNT_W = 16;

    // ID/EX payload width, derived from the packed field widths of that boundary
    localparam int ID_EX_W = 189;

endpackage

// File: rtl/pipe_entry.sv
// -----------------------------------------------------------------------------
// pipe_entry
//   One storage slot of a pipeline stage: a valid bit plus a WIDTH-bit payload.
//   Used twice inside pipe_stage_skid (main entry and skid entry).
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset (empties the slot)
//   load   in   capture d and mark the slot valid
//   clear  in   empty the slot and park DEFAULT_VAL (wins over load)
//   d      in   payload to capture
//   valid  out  slot holds a payload
//   data   out  stored payload (DEFAULT_VAL when empty)
// -----------------------------------------------------------------------------
module pipe_entry
    import pipe_stage_skid_pkg::*;
#(
    parameter int                 WIDTH       = PIPE_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0]   DEFAULT_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // Slot register. Clearing always parks DEFAULT_VAL so an empty slot
    // never leaks a stale payload onto the datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= DEFAULT_VAL;
        end else if (clear) begin
            valid <= 1'b0;
            data  <= DEFAULT_VAL;
        end else if (load) begin
            valid <= 1'b1;
            data  <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
//   Generic pipeline-stage register with a valid/ready handshake backed by a
//   2-entry skid buffer (main + skid), plus the legacy stall/bubble hazard
//   controls. in_ready comes straight from a flop (the skid valid bit), so
//   there is no combinational path from out_ready to in_ready.
//
// Parameters:
//   WIDTH        payload width (1..512)
//   DEFAULT_VAL  payload held while the stage is empty
//   CNT_W        performance counter width (only with PIPE_STAGE_PERF_EN)
//
// Ports:
//   clk, rst_n         clock / asynchronous active-low reset
//   stall              freeze all stage state, no transfers
//   bubble             flush both entries to DEFAULT_VAL
//   in_valid/in_ready/in_data     upstream handshake
//   out_valid/out_ready/out_data  downstream handshake
//   stall_cnt, bubble_cnt         saturating counters (PIPE_STAGE_PERF_EN)
//
// Optional feature macro: PIPE_STAGE_PERF_EN. When undefined, the counter
// parameter, ports and logic are absent and the port list ends at out_data.
// Legacy use: tie in_valid=1 and out_ready=1 for a plain stall/bubble register.
// -----------------------------------------------------------------------------
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int                 WIDTH       = PIPE_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0]   DEFAULT_VAL = '0
`ifdef PIPE_STAGE_PERF_EN
    ,
    parameter int                 CNT_W       = PIPE_CNT_W
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             bubble,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
`endif
);

    logic             main_valid;
    logic [WIDTH-1:0] main_data;
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;

    logic             acc;
    logic             rel;
    logic             main_load;
    logic             main_clear;
    logic [WIDTH-1:0] main_d;
    logic             skid_load;
    logic             skid_clear;

    assign in_ready  = !skid_valid;
    assign out_valid = main_valid;
    assign out_data  = main_data;

    // Entry control. A stall forces every load/clear low so both entries hold.
    // Bubble clears both entries and drops any payload accepted that cycle.
    // Main refills from skid when skid is occupied, otherwise from upstream;
    // a release with nothing behind it empties main. Skid only captures when
    // main is occupied and not leaving, which is also the only way in_ready
    // can fall.
    always_comb begin
        acc        = 1'b0;
        rel        = 1'b0;
        main_load  = 1'b0;
        main_clear = 1'b0;
        main_d     = in_data;
        skid_load  = 1'b0;
        skid_clear = 1'b0;

        acc = in_valid && in_ready && !stall;
        rel = main_valid && out_ready && !stall;

        if (skid_valid) begin
            main_d = skid_data;
        end

        if (!stall) begin
            if (bubble) begin
                main_clear = 1'b1;
                skid_clear = 1'b1;
            end else begin
                main_load  = (!main_valid && acc) || (rel && (skid_valid || acc));
                main_clear = rel && !skid_valid && !acc;
                skid_load  = main_valid && !rel && acc;
                skid_clear = rel && skid_valid;
            end
        end
    end

    pipe_entry #(
        .WIDTH       (WIDTH),
        .DEFAULT_VAL (DEFAULT_VAL)
    ) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (main_load),
        .clear (main_clear),
        .d     (main_d),
        .valid (main_valid),
        .data  (main_data)
    );

    pipe_entry #(
        .WIDTH       (WIDTH),
        .DEFAULT_VAL (DEFAULT_VAL)
    ) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (in_data),
        .valid (skid_valid),
        .data  (skid_data)
    );

`ifdef PIPE_STAGE_PERF_EN
    // Saturating hazard counters. A bubble under stall is ignored by the
    // stage, so it is not counted as an effective bubble either.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else if (stall) begin
            if (stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end else if (bubble) begin
            if (bubble_cnt != '1) begin
                bubble_cnt <= bubble_cnt + 1'b1;
            end
        end
    end
`endif

endmodule
